csi2tx_payload_crc_buf: RTL

- Downstream of the pixel-to-byte packers (RGB666 and siblings); consumes their 32-bit `dw`/`dw_vld` word stream for one long packet.
- Trims the final word to the programmed word count (WC, in bytes) and computes the CSI-2 payload CRC-16.
- Buffers words in a small FIFO, then presents payload words plus a trailing CRC word to the lane distributor over a valid/ready handshake.
- The packer side has no backpressure, so overflow is detected and flagged, never stalled.

---
 rtl/csi2tx_payload_crc_buf_pkg.sv | 39 +++
 rtl/csi2tx_payload_crc_buf_if.sv | 13 +
 rtl/csi2tx_sync_fifo.sv | 47 ++++
 rtl/csi2tx_payload_crc_buf.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/csi2tx_payload_crc_buf_pkg.sv
// Shared types and CRC helpers for the CSI-2 TX payload CRC/buffer stage.
package csi2tx_payload_crc_buf_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WC_W   = 16;
  localparam int unsigned CRC_W  = 16;

  localparam logic [CRC_W-1:0] CRC_POLY = 16'h8408;
  localparam logic [CRC_W-1:0] CRC_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic              last;
  } fifo_word_t;

  localparam int unsigned FIFO_W = $bits(fifo_word_t);

  // Reflected CRC-16 update over one byte, LSB first.
  function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                  input logic [7:0]       data_byte);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_byte[i]) c = (c >> 1) ^ CRC_POLY;
      else                     c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/csi2tx_payload_crc_buf_if.sv
// Output word stream towards the lane distributor (valid/ready).
interface csi2tx_payload_crc_buf_if;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_last;
  logic        out_vld;
  logic        out_rdy;

  modport master (output out_data, output out_be, output out_last, output out_vld,
                  input  out_rdy);
  modport slave  (input  out_data, input  out_be, input  out_last, input  out_vld,
                  output out_rdy);
endinterface

// File: rtl/csi2tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is accepted only with a pop.
module csi2tx_sync_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: reads are qualified by empty_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/csi2tx_payload_crc_buf.sv
// Trims packer words to the packet word count, appends the CSI-2 payload CRC-16 and buffers the result.
module csi2tx_payload_crc_buf
  import csi2tx_payload_crc_buf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pkt_start,
  input  logic [WC_W-1:0]           wc,
  input  logic [DATA_W-1:0]         dw,
  input  logic                      dw_vld,
  input  logic                      err_clr,
  output logic                      busy,
  output logic                      ovf_err,
  output logic                      excess_err,
  csi2tx_payload_crc_buf_if.master  out_if
);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  bytes_left_q, bytes_left_d;
  logic [CRC_W-1:0] crc_q, crc_d, crc_word;
  logic             ovf_q, ovf_d, exc_q, exc_d;
  logic [BE_W-1:0]  be;
  logic [WC_W-1:0]  take;
  logic             push, pop, full, empty, pay_push;
  fifo_word_t       push_word, head, out_word;

  // Byte enables and byte consumption for the current payload word.
  always_comb begin
    be   = 4'b1111;
    take = WC_W'(4);
    if (bytes_left_q < WC_W'(4)) begin
      take = bytes_left_q;
      case (bytes_left_q[1:0])
        2'd1:    be = 4'b0001;
        2'd2:    be = 4'b0011;
        2'd3:    be = 4'b0111;
        default: be = 4'b0000;
      endcase
    end
  end

  // Four unrolled byte stages, each gated by its enable.
  always_comb begin
    crc_word = crc_q;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) crc_word = crc16_byte(crc_word, dw[8*i +: 8]);
    end
  end

  assign pop      = !empty && out_if.out_rdy;
  assign pay_push = (state_q == ST_PAYLOAD) && dw_vld;

  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    crc_d        = crc_q;
    push         = 1'b0;
    push_word    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pkt_start) begin
          bytes_left_d = wc;
          crc_d        = CRC_SEED;
          state_d      = (wc == '0) ? ST_CRC : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (dw_vld) begin
          push           = 1'b1;
          push_word.data = dw;
          push_word.be   = be;
          crc_d          = crc_word;
          bytes_left_d   = bytes_left_q - take;
          if (bytes_left_d == '0) state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        push           = 1'b1;
        push_word.data = {16'h0000, crc_q};
        push_word.be   = 4'b0011;
        push_word.last = 1'b1;
        // The CRC word is never dropped: hold here until the FIFO can take it.
        if (!full || pop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q | (pay_push && full && !pop);
    exc_d = exc_q | (dw_vld && (state_q != ST_PAYLOAD));
    if (err_clr) begin
      ovf_d = 1'b0;
      exc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bytes_left_q <= '0;
      crc_q        <= CRC_SEED;
      ovf_q        <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      crc_q        <= crc_d;
      ovf_q        <= ovf_d;
      exc_q        <= exc_d;
    end
  end

  csi2tx_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Head is forced to zero while empty so idle outputs read as 0.
  assign out_word         = empty ? '0 : head;
  assign out_if.out_data  = out_word.data;
  assign out_if.out_be    = out_word.be;
  assign out_if.out_last  = out_word.last;
  assign out_if.out_vld   = !empty;

  assign busy       = (state_q != ST_IDLE) || !empty;
  assign ovf_err    = ovf_q;
  assign excess_err = exc_q;

endmodule
